// File: rtl/if_fetch_if.sv
// Instruction-memory request/grant bus between the fetch unit (master) and memory (slave).
interface if_fetch_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, keeps one request outstanding to instruction memory,
// and presents PC/instruction to IF/ID with freeze skid and branch redirect.
//
//  state  | meaning
//  S_REQ  | mem_req asserted at pc_reg, waiting for grant
//  S_WAIT | request granted, waiting for rvalid (dropped if kill is set)
//  S_HOLD | data returned while output slot was frozen; parked in skid
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    if_fetch_if.master         mem,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               if_valid_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_reg_q, pc_reg_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               kill_q, kill_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_reg_q     <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            valid_q      <= 1'b0;
            pc_out_q     <= '0;
            instr_q      <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_reg_q     <= pc_reg_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            valid_q      <= valid_d;
            pc_out_q     <= pc_out_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_reg_d     = pc_reg_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        valid_d      = valid_q;
        pc_out_d     = pc_out_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (valid_q && !freeze_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (mem.mem_gnt) begin
                    req_pc_d = pc_reg_q;
                    pc_reg_d = pc_reg_q + STEP;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d = S_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!valid_q || !freeze_i) begin
                        pc_out_d = req_pc_q + STEP;
                        instr_d  = mem.mem_rdata;
                        valid_d  = 1'b1;
                    end else begin
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = mem.mem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!freeze_i) begin
                    pc_out_d = skid_pc_q + STEP;
                    instr_d  = skid_instr_q;
                    valid_d  = 1'b1;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above; an in-flight response must be killed.
        if (branch_taken_i) begin
            pc_reg_d = branch_addr_i;
            valid_d  = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    if (mem.mem_gnt) begin
                        kill_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_addr  = pc_reg_q;
    assign pc_o          = pc_out_q;
    assign instruction_o = instr_q;
    assign if_valid_o    = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder, program-order stream model and directed scenarios.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] br_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        if_valid;

    int tests = 0;
    int fails = 0;
    int lat   = 1;

    if_fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    if_fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze_i      (freeze),
        .branch_taken_i(br),
        .branch_addr_i (br_addr),
        .mem           (bus),
        .pc_o          (pc),
        .instruction_o (instr),
        .if_valid_o    (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE000_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: grants every request, returns data lat cycles after the grant.
    initial begin : memory
        bit          hs;
        logic [31:0] hs_addr;
        bit          pend;
        logic [31:0] pend_addr;
        int          cnt;
        pend = 0;
        pend_addr = '0;
        cnt = 0;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            hs      = bus.mem_req && bus.mem_gnt && !rst;
            hs_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (hs) begin
                pend      = 1;
                pend_addr = hs_addr;
                cnt       = lat - 1;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
            if (pend && cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word(pend_addr);
                pend           = 0;
            end
        end
    end

    // Program-order model: every consumed slot must be the next address in sequence.
    initial begin : compare
        logic [31:0] model_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        bit          expect_inv;
        bit          prev_hold;
        model_pc   = 32'h0;
        expect_inv = 0;
        prev_hold  = 0;
        prev_pc    = '0;
        prev_instr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_pc   = 32'h0;
                expect_inv = 1;
                prev_hold  = 0;
            end else begin
                if (expect_inv) begin
                    chk("valid_after_flush", {31'b0, if_valid}, 32'd1 - 32'd1);
                    expect_inv = 0;
                end
                if (prev_hold) begin
                    chk("hold_valid", {31'b0, if_valid}, 32'd1);
                    chk("hold_pc", pc, prev_pc);
                    chk("hold_instr", instr, prev_instr);
                end
                if (if_valid && !freeze) begin
                    chk("stream_pc", pc, model_pc + 32'd4);
                    chk("stream_instr", instr, mem_word(model_pc));
                    model_pc = model_pc + 32'd4;
                end
                if (br) begin
                    model_pc   = br_addr;
                    expect_inv = 1;
                end
                prev_hold  = if_valid && freeze && !br;
                prev_pc    = pc;
                prev_instr = instr;
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        freeze = 1'b0;
        br = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!if_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin : stimulus
        rst = 1'b1;
        freeze = 1'b0;
        br = 1'b0;
        br_addr = '0;

        // Reset state, then zero-wait streaming.
        do_reset(2);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        for (int i = 0; i < 7; i++) begin
            chk("zw_valid", {31'b0, if_valid}, (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk("zw_mem_addr", bus.mem_addr, 32'(2 * i));
            if (i >= 2 && i % 2 == 0) begin
                chk("zw_pc", pc, 32'(2 * i));
                chk("zw_instr", instr, mem_word(32'(2 * i - 4)));
            end
            if (i < 6) @(negedge clk);
        end

        // Freeze while the addr-4 response arrives.
        do_reset(4);
        next_cycle();
        next_cycle();
        freeze = 1'b1;
        @(negedge clk);
        chk("frz_pc_c2", pc, 32'd4);
        next_cycle();
        @(negedge clk);
        chk("frz_pc_c3", pc, 32'd4);
        next_cycle();
        freeze = 1'b0;
        @(negedge clk);
        chk("frz_hold_req", {31'b0, bus.mem_req}, 32'd0);
        chk("frz_instr_c4", instr, mem_word(32'd0));
        next_cycle();
        @(negedge clk);
        chk("frz_rel_valid", {31'b0, if_valid}, 32'd1);
        chk("frz_rel_pc", pc, 32'd8);
        chk("frz_rel_instr", instr, mem_word(32'd4));

        // Branch during WAIT with slow memory: in-flight data must be killed.
        lat = 3;
        do_reset(4);
        next_cycle();
        br = 1'b1;
        br_addr = 32'h100;
        next_cycle();
        br = 1'b0;
        @(negedge clk);
        chk("brw_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("brw_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("brw_mem_addr", bus.mem_addr, 32'h100);
        chk("brw_valid2", {31'b0, if_valid}, 32'd0);
        wait_valid("brw");
        chk("brw_pc", pc, 32'h104);
        chk("brw_instr", instr, 32'hE000_0100);

        // Branch together with rvalid and freeze.
        lat = 1;
        do_reset(4);
        next_cycle();
        next_cycle();
        freeze = 1'b1;
        next_cycle();
        br = 1'b1;
        br_addr = 32'h200;
        @(negedge clk);
        chk("brf_valid_before", {31'b0, if_valid}, 32'd1);
        next_cycle();
        br = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        chk("brf_valid", {31'b0, if_valid}, 32'd0);
        chk("brf_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("brf_mem_addr", bus.mem_addr, 32'h200);
        wait_valid("brf");
        chk("brf_pc", pc, 32'h204);
        chk("brf_instr", instr, 32'hE000_0200);

        // Reset during WAIT with a stray response arriving afterwards.
        do_reset(4);
        next_cycle();
        lat = 2;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_mem_req", {31'b0, bus.mem_req}, 32'd1);
        chk("rstw_mem_addr", bus.mem_addr, 32'h0);
        chk("rstw_valid", {31'b0, if_valid}, 32'd0);
        wait_valid("rstw");
        chk("rstw_pc", pc, 32'h4);
        chk("rstw_instr", instr, 32'hE000_0000);

        // PC wraps modulo 2^32.
        next_cycle();
        br = 1'b1;
        br_addr = 32'hFFFF_FFFC;
        next_cycle();
        br = 1'b0;
        @(negedge clk);
        wait_valid("wrap");
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_instr", instr, 32'h1FFF_FFFC);

        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
